// File: rtl/billiard_pkg.sv
// rtl/billiard_pkg.sv - shared widths, types and helpers for the cue-ball motion stage
//
// Purpose : common constants (coordinate/velocity/fraction widths), the motion
//           state type, the signed fixed-point position type and small helpers
//           used by ball_motion_controller and ball_axis_integrator.
// Ports   : none (package)

package billiard_pkg;

  localparam int COORD_W   = 11;
  localparam int VEL_W     = 11;
  localparam int FRAC_BITS = 6;
  localparam int POS_W     = COORD_W + FRAC_BITS;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } motion_state_t;

  // Position: integer pixels in the upper COORD_W bits, FRAC_BITS of sub-pixel below.
  typedef logic signed [POS_W-1:0] fixed_pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  // Two's-complement negation that maps the most negative value to the most
  // positive one instead of wrapping back onto itself.
  function automatic vel_t neg_sat(input vel_t v);
    if (v == {1'b1, {(VEL_W-1){1'b0}}})
      return {1'b0, {(VEL_W-1){1'b1}}};
    return -v;
  endfunction

  function automatic fixed_pos_t to_fixed(input logic [COORD_W-1:0] c);
    return {c, {FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/ball_axis_integrator.sv
// rtl/ball_axis_integrator.sv - one-axis position step, cushion reflect, friction and stop
//
// Purpose : purely combinational next-frame computation for a single axis.
// Ports   : pos      in  POS_W  current fixed-point position
//           vel      in  VEL_W  current signed velocity (LSB = 1/2^FRAC_BITS px/frame)
//           pos_next out POS_W  position after step and cushion clamp
//           vel_next out VEL_W  velocity after reflect, friction and stop threshold

module ball_axis_integrator
  import billiard_pkg::*;
#(
  parameter int MIN            = 0,
  parameter int MAX            = 600,
  parameter int FRICTION_SHIFT = 5,
  parameter int STOP_THRESHOLD = 2
) (
  input  fixed_pos_t pos,
  input  vel_t       vel,
  output fixed_pos_t pos_next,
  output vel_t       vel_next
);

  // One extra bit so pos + vel can never overflow.
  localparam int SUM_W = POS_W + 1;
  localparam int INT_W = SUM_W - FRAC_BITS;
  localparam int MAG_W = VEL_W + 1;

  localparam logic signed [INT_W-1:0] MIN_I = INT_W'(MIN);
  localparam logic signed [INT_W-1:0] MAX_I = INT_W'(MAX);
  localparam fixed_pos_t MIN_POS = to_fixed(COORD_W'(MIN));
  localparam fixed_pos_t MAX_POS = to_fixed(COORD_W'(MAX));
  localparam logic [MAG_W-1:0] ONE  = MAG_W'(1);
  localparam logic [MAG_W-1:0] STOP = MAG_W'(STOP_THRESHOLD);

  logic signed [SUM_W-1:0] sum;
  logic signed [INT_W-1:0] sum_int;
  vel_t                    refl;
  logic        [MAG_W-1:0] ext;
  logic        [MAG_W-1:0] mag;
  logic        [MAG_W-1:0] dec;
  logic        [VEL_W-1:0] mag_f;

  always_comb begin
    sum      = {pos[POS_W-1], pos} + {{(SUM_W-VEL_W){vel[VEL_W-1]}}, vel};
    sum_int  = sum[SUM_W-1:FRAC_BITS];
    pos_next = sum[POS_W-1:0];
    refl     = vel;

    if (sum_int < MIN_I) begin
      pos_next = MIN_POS;
      refl     = neg_sat(vel);
    end else if (sum_int > MAX_I) begin
      pos_next = MAX_POS;
      refl     = neg_sat(vel);
    end

    // Friction works on magnitude; the extra bit holds |-2^(VEL_W-1)|.
    ext = {refl[VEL_W-1], refl};
    mag = ext[MAG_W-1] ? (~ext + ONE) : ext;
    dec = mag >> FRICTION_SHIFT;
    if (dec == '0)
      dec = ONE;

    mag_f = (mag > dec) ? VEL_W'(mag - dec) : '0;
    if ({1'b0, mag_f} <= STOP)
      mag_f = '0;

    vel_next = refl[VEL_W-1] ? -mag_f : mag_f;
  end

endmodule

// File: rtl/ball_motion_controller.sv
// rtl/ball_motion_controller.sv - cue-ball position integration, friction and cushion reflection
//
// Purpose : holds ball position/velocity, accepts shots and re-spots, and steps
//           the ball once per frame while it is moving.
// Ports   : clk                 in   1      clock
//           resetN              in   1      asynchronous reset, active-low
//           startOfFrame        in   1      one-cycle frame tick
//           newVelocityX/Y      in   11     signed shot velocity
//           velocityWriteEnable in   1      one-cycle shot strobe (IDLE only)
//           placeBall           in   1      one-cycle re-spot request
//           placeX/placeY       in   11     re-spot top-left (integer pixels)
//           topLeftX/topLeftY   out  11     integer part of position (floor)
//           velocityX/velocityY out  11     current signed velocity
//           ballMoving          out  1      high while MOVING

module ball_motion_controller
  import billiard_pkg::*;
#(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 600,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 440,
  parameter int INIT_X         = 100,
  parameter int INIT_Y         = 100,
  parameter int FRICTION_SHIFT = 5,
  parameter int STOP_THRESHOLD = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [VEL_W-1:0]   newVelocityX,
  input  logic [VEL_W-1:0]   newVelocityY,
  input  logic               velocityWriteEnable,
  input  logic               placeBall,
  input  logic [COORD_W-1:0] placeX,
  input  logic [COORD_W-1:0] placeY,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic [VEL_W-1:0]   velocityX,
  output logic [VEL_W-1:0]   velocityY,
  output logic               ballMoving
);

  localparam fixed_pos_t INIT_POS_X = to_fixed(COORD_W'(INIT_X));
  localparam fixed_pos_t INIT_POS_Y = to_fixed(COORD_W'(INIT_Y));

  motion_state_t state;
  fixed_pos_t    pos_x, pos_y, pos_x_next, pos_y_next;
  vel_t          vel_x, vel_y, vel_x_next, vel_y_next;

  ball_axis_integrator #(
    .MIN(X_MIN), .MAX(X_MAX),
    .FRICTION_SHIFT(FRICTION_SHIFT), .STOP_THRESHOLD(STOP_THRESHOLD)
  ) u_axis_x (
    .pos(pos_x), .vel(vel_x), .pos_next(pos_x_next), .vel_next(vel_x_next)
  );

  ball_axis_integrator #(
    .MIN(Y_MIN), .MAX(Y_MAX),
    .FRICTION_SHIFT(FRICTION_SHIFT), .STOP_THRESHOLD(STOP_THRESHOLD)
  ) u_axis_y (
    .pos(pos_y), .vel(vel_y), .pos_next(pos_y_next), .vel_next(vel_y_next)
  );

  // Priority: re-spot, then shot (IDLE only), then frame step (MOVING only).
  // A shot on a frame tick only loads; the first step happens on the next tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      pos_x <= INIT_POS_X;
      pos_y <= INIT_POS_Y;
      vel_x <= '0;
      vel_y <= '0;
    end else if (placeBall) begin
      state <= IDLE;
      pos_x <= to_fixed(placeX);
      pos_y <= to_fixed(placeY);
      vel_x <= '0;
      vel_y <= '0;
    end else if (velocityWriteEnable && state == IDLE) begin
      vel_x <= newVelocityX;
      vel_y <= newVelocityY;
      state <= (newVelocityX != '0 || newVelocityY != '0) ? MOVING : IDLE;
    end else if (startOfFrame && state == MOVING) begin
      pos_x <= pos_x_next;
      pos_y <= pos_y_next;
      vel_x <= vel_x_next;
      vel_y <= vel_y_next;
      state <= (vel_x_next == '0 && vel_y_next == '0) ? IDLE : MOVING;
    end
  end

  // Dropping the fraction bits is the arithmetic shift right (floor).
  assign topLeftX   = pos_x[POS_W-1:FRAC_BITS];
  assign topLeftY   = pos_y[POS_W-1:FRAC_BITS];
  assign velocityX  = vel_x;
  assign velocityY  = vel_y;
  assign ballMoving = (state == MOVING);

endmodule
